// File: rtl/phase_slot_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// phase_slot_scheduler_pkg
// Shared definitions for the 4-phase slot scheduler:
//   NPH     - number of ring phases / requesters
//   slot_t  - phase (slot) index type
//   state_e - scheduler FSM state encoding
// ---------------------------------------------------------------------------
package phase_slot_scheduler_pkg;

    localparam int NPH = 4;

    typedef logic [1:0] slot_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

endpackage : phase_slot_scheduler_pkg

// File: rtl/phase_slot_scheduler_rr_pick4.sv
// ---------------------------------------------------------------------------
// phase_slot_scheduler_rr_pick4
// Combinational round-robin picker over four requesters.
// Ports:
//   req_i  [3:0] - request vector
//   last_i [1:0] - index of the most recent winner
//   win_o  [1:0] - first requester found searching from last_i+1 (mod 4);
//                  equals last_i when nothing is requested
//   any_o        - at least one request is present
// ---------------------------------------------------------------------------
module phase_slot_scheduler_rr_pick4
    import phase_slot_scheduler_pkg::*;
(
    input  logic [NPH-1:0] req_i,
    input  slot_t          last_i,
    output slot_t          win_o,
    output logic           any_o
);

    slot_t idx;

    // Walk the ring starting one past the last winner; the 4th step lands
    // back on last_i itself so a sole requester can win again.
    always_comb begin
        win_o = last_i;
        any_o = 1'b0;
        idx   = last_i;
        for (int o = 0; o < NPH; o++) begin
            idx = idx + 2'd1;
            if (!any_o && req_i[idx]) begin
                win_o = idx;
                any_o = 1'b1;
            end
        end
    end

endmodule : phase_slot_scheduler_rr_pick4

// File: rtl/phase_slot_scheduler.sv
// ---------------------------------------------------------------------------
// phase_slot_scheduler
// Time-shares a 4-phase ring resource between four requesters: one phase
// at a time, round-robin priority, bounded dwell, one idle gap cycle
// between consecutive grants. All outputs are registered.
// Ports:
//   Phase_Count     - clock (rising edge)
//   Clear           - synchronous active-low reset
//   Enable          - run; low releases any grant and idles the scheduler
//   Req[3:0]        - level requests, Req[i] asks for phase i
//   Done[3:0]       - early release by the owner of phase i
//   Phase0..Phase3  - one-hot (or all-zero) phase grants
//   Slot[1:0]       - index of the current or last granted phase
//   Busy            - high while any phase output is high
//   Wrap            - one-cycle pulse on the first cycle of a grant whose
//                     index is <= the previous grant index
// Handshake: Req[i] is a level held by the requester until served; a grant
// ends when the owner drops Req, pulses Done, the dwell expires or Enable
// falls, and is always followed by exactly one all-low gap cycle.
// ---------------------------------------------------------------------------
module phase_slot_scheduler
    import phase_slot_scheduler_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int DW_W  = 3
) (
    input  logic           Phase_Count,
    input  logic           Clear,
    input  logic           Enable,
    input  logic [NPH-1:0] Req,
    input  logic [NPH-1:0] Done,
    output logic           Phase0,
    output logic           Phase1,
    output logic           Phase2,
    output logic           Phase3,
    output logic [1:0]     Slot,
    output logic           Busy,
    output logic           Wrap
);

    localparam logic [DW_W-1:0] DWELL_LD = DW_W'(DWELL - 1);

    state_e          state_q, state_d;
    logic [NPH-1:0]  phase_q, phase_d;
    slot_t           last_q,  last_d;
    logic            busy_q,  busy_d;
    logic            wrap_q,  wrap_d;
    logic [DW_W-1:0] cnt_q,   cnt_d;

    slot_t win;
    logic  any_req;
    logic  release_grant;

    phase_slot_scheduler_rr_pick4 u_pick (
        .req_i  (Req),
        .last_i (last_q),
        .win_o  (win),
        .any_o  (any_req)
    );

    // While granting, last_q is the owner, so its Req/Done bits are the
    // only ones that can end the grant.
    assign release_grant = Done[last_q] | ~Req[last_q] |
                           (cnt_q == '0) | ~Enable;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        last_d  = last_q;
        busy_d  = busy_q;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (Enable && any_req) begin
                    state_d = ST_GRANT;
                    phase_d = 4'b0001 << win;
                    last_d  = win;
                    busy_d  = 1'b1;
                    wrap_d  = (win <= last_q);
                    cnt_d   = DWELL_LD;
                end else begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                    busy_d  = 1'b0;
                end
            end
            ST_GRANT: begin
                if (release_grant) begin
                    state_d = ST_GAP;
                    phase_d = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Phase_Count) begin
        if (!Clear) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            last_q  <= 2'd3;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Phase0 = phase_q[0];
    assign Phase1 = phase_q[1];
    assign Phase2 = phase_q[2];
    assign Phase3 = phase_q[3];
    assign Slot   = last_q;
    assign Busy   = busy_q;
    assign Wrap   = wrap_q;

endmodule : phase_slot_scheduler

// File: tb/tb_phase_slot_scheduler.sv
// Bench for phase_slot_scheduler: DWELL=4 instance (u_dut0) and DWELL=1
// instance (u_dut1). Expected output vectors {Phase[3:0],Slot,Busy,Wrap}
// are hand-derived and queued by the drivers; monitors pop one per edge.
module tb_phase_slot_scheduler;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr0 = 1'b0, en0 = 1'b0;
    logic [3:0] req0 = '0, done0 = '0;
    logic       p0_0, p0_1, p0_2, p0_3, busy0, wrap0;
    logic [1:0] slot0;

    logic       clr1 = 1'b0, en1 = 1'b0;
    logic [3:0] req1 = '0, done1 = '0;
    logic       p1_0, p1_1, p1_2, p1_3, busy1, wrap1;
    logic [1:0] slot1;

    phase_slot_scheduler #(.DWELL(4), .DW_W(3)) u_dut0 (
        .Phase_Count (clk),
        .Clear       (clr0),
        .Enable      (en0),
        .Req         (req0),
        .Done        (done0),
        .Phase0      (p0_0),
        .Phase1      (p0_1),
        .Phase2      (p0_2),
        .Phase3      (p0_3),
        .Slot        (slot0),
        .Busy        (busy0),
        .Wrap        (wrap0)
    );

    phase_slot_scheduler #(.DWELL(1), .DW_W(3)) u_dut1 (
        .Phase_Count (clk),
        .Clear       (clr1),
        .Enable      (en1),
        .Req         (req1),
        .Done        (done1),
        .Phase0      (p1_0),
        .Phase1      (p1_1),
        .Phase2      (p1_2),
        .Phase3      (p1_3),
        .Slot        (slot1),
        .Busy        (busy1),
        .Wrap        (wrap1)
    );

    // ---------------- scoreboard ----------------
    logic [7:0] exp0_q[$];
    logic [7:0] exp1_q[$];
    string      name0_q[$];
    string      name1_q[$];
    int         errors = 0;
    int         checks = 0;

    function automatic logic [7:0] ev(input logic [3:0] ph, input logic [1:0] sl,
                                      input logic wr);
        return {ph, sl, |ph, wr};
    endfunction

    task automatic compare(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got ph=%b slot=%0d busy=%b wrap=%b, expected ph=%b slot=%0d busy=%b wrap=%b",
                     nm, got[7:4], got[3:2], got[1], got[0],
                     exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    // monitors: one pop per active edge, sampled 1 time unit after it
    always @(posedge clk) begin
        #1;
        if (exp0_q.size() > 0)
            compare(name0_q.pop_front(), {p0_3, p0_2, p0_1, p0_0, slot0, busy0, wrap0},
                    exp0_q.pop_front());
        if (exp1_q.size() > 0)
            compare(name1_q.pop_front(), {p1_3, p1_2, p1_1, p1_0, slot1, busy1, wrap1},
                    exp1_q.pop_front());
    end

    // ---------------- drivers ----------------
    task automatic step0(input logic clr, input logic en, input logic [3:0] req,
                         input logic [3:0] done, input logic [3:0] eph,
                         input logic [1:0] eslot, input logic ewrap, input string nm);
        @(negedge clk);
        clr0 = clr; en0 = en; req0 = req; done0 = done;
        exp0_q.push_back(ev(eph, eslot, ewrap));
        name0_q.push_back(nm);
    endtask

    task automatic step1(input logic clr, input logic en, input logic [3:0] req,
                         input logic [3:0] eph, input logic [1:0] eslot,
                         input logic ewrap, input string nm);
        @(negedge clk);
        clr1 = clr; en1 = en; req1 = req; done1 = '0;
        exp1_q.push_back(ev(eph, eslot, ewrap));
        name1_q.push_back(nm);
    endtask

    // n grant cycles on phase ph (Wrap expected only on the first), then the gap
    task automatic grant0(input logic [3:0] req, input int ph, input int n,
                          input logic first_wrap, input string nm);
        logic [3:0] onehot;
        onehot = 4'b0001 << ph;
        for (int i = 0; i < n; i++)
            step0(1'b1, 1'b1, req, 4'b0000, onehot, 2'(ph),
                  (i == 0) ? first_wrap : 1'b0, nm);
        step0(1'b1, 1'b1, req, 4'b0000, 4'b0000, 2'(ph), 1'b0, {nm, "_gap"});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // reset, all four requesting
        step0(1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd3, 1'b0, "rst_a");
        step0(1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd3, 1'b0, "rst_b");
        // full rotation 0,1,2,3 then back to 0 with Wrap
        grant0(4'b1111, 0, 4, 1'b1, "rot_p0");
        grant0(4'b1111, 1, 4, 1'b0, "rot_p1");
        grant0(4'b1111, 2, 4, 1'b0, "rot_p2");
        grant0(4'b1111, 3, 4, 1'b0, "rot_p3");
        grant0(4'b1111, 0, 4, 1'b1, "rot_p0_wrap");
        step0(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, "to_idle");

        // sole requester on phase 2: first grant from last=0 does not wrap
        grant0(4'b0100, 2, 4, 1'b0, "solo_p2_a");
        grant0(4'b0100, 2, 4, 1'b1, "solo_p2_b");
        grant0(4'b0100, 2, 4, 1'b1, "solo_p2_c");

        // early Done on owner, Done on non-owner ignored
        step0(1'b1, 1'b1, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, "done_p0_c1");
        step0(1'b1, 1'b1, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b0, "done_p0_c2");
        step0(1'b1, 1'b1, 4'b0011, 4'b0001, 4'b0000, 2'd0, 1'b0, "done_p0_rel");
        step0(1'b1, 1'b1, 4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b0, "p1_c1");
        step0(1'b1, 1'b1, 4'b0011, 4'b1000, 4'b0010, 2'd1, 1'b0, "done3_ignored");
        step0(1'b1, 1'b1, 4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b0, "p1_c3");
        step0(1'b1, 1'b1, 4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b0, "p1_c4");
        step0(1'b1, 1'b1, 4'b0011, 4'b0000, 4'b0000, 2'd1, 1'b0, "p1_gap");

        // Enable dropped in 2nd cycle of a phase 1 grant
        step0(1'b1, 1'b1, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, "en_p1_c1");
        step0(1'b1, 1'b1, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, "en_p1_c2");
        step0(1'b1, 1'b0, 4'b0010, 4'b0000, 4'b0000, 2'd1, 1'b0, "en_low_gap");
        step0(1'b1, 1'b0, 4'b0010, 4'b0000, 4'b0000, 2'd1, 1'b0, "en_low_idle");
        step0(1'b1, 1'b0, 4'b0011, 4'b0000, 4'b0000, 2'd1, 1'b0, "en_low_stay");
        grant0(4'b0011, 0, 4, 1'b1, "reen_p0");

        // Clear mid phase 3 grant, then regrant phase 3
        step0(1'b1, 1'b1, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0, "p3_c1");
        step0(1'b1, 1'b1, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0, "p3_c2");
        step0(1'b0, 1'b1, 4'b1000, 4'b0000, 4'b0000, 2'd3, 1'b0, "clr_mid_p3");
        step0(1'b1, 1'b1, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, "post_clr_p3");
        step0(1'b1, 1'b1, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0, "post_clr_p3_c2");
        // Clear mid phase 0 grant: Slot must return to 3
        step0(1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0000, 2'd3, 1'b0, "clr_p3_again");
        step0(1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, "p0_after_clr");
        step0(1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0000, 2'd3, 1'b0, "clr_mid_p0");

        // DWELL=1 instance, Req=1010
        step1(1'b0, 1'b1, 4'b1010, 4'b0000, 2'd3, 1'b0, "d1_rst");
        for (int r = 0; r < 3; r++) begin
            step1(1'b1, 1'b1, 4'b1010, 4'b0010, 2'd1, 1'b1, "d1_p1");
            step1(1'b1, 1'b1, 4'b1010, 4'b0000, 2'd1, 1'b0, "d1_p1_gap");
            step1(1'b1, 1'b1, 4'b1010, 4'b1000, 2'd3, 1'b0, "d1_p3");
            step1(1'b1, 1'b1, 4'b1010, 4'b0000, 2'd3, 1'b0, "d1_p3_gap");
        end

        // bounded drain of the scoreboard
        for (int i = 0; i < 5 && (exp0_q.size() + exp1_q.size()) > 0; i++)
            @(posedge clk);
        #2;
        checks++;
        if ((exp0_q.size() + exp1_q.size()) != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, expected 0",
                     exp0_q.size() + exp1_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_phase_slot_scheduler
